// File: rtl/mpsoc_dbg_bytefifo.sv
// mpsoc_dbg_bytefifo: byte FIFO for the JTAG serial port data paths.
// Show-ahead circular buffer with registered occupancy words (COUNT/FREE)
// and registered FULL/EMPTY. The occupancy words feed clock-domain sync
// registers downstream; this block itself is single-clock.
module mpsoc_dbg_bytefifo #(
    parameter int DEPTH = 8,  // power of two, 2..8 so COUNT/FREE fit in 4 bits
    parameter int DW    = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CLR,
    input  logic [DW-1:0] DATA_IN,
    input  logic          WRITE_EN,
    input  logic          READ_EN,
    output logic [DW-1:0] DATA_OUT,
    output logic [3:0]    COUNT,
    output logic [3:0]    FREE,
    output logic          FULL,
    output logic          EMPTY,
    output logic          OVERFLOW,
    output logic          UNDERFLOW
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_W = 4'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          push_ok;
    logic          pop_ok;
    logic [3:0]    count_nxt;

    // A pop is only refused when empty. A push into a full FIFO is accepted
    // when a pop in the same cycle frees the slot being written (wr_ptr ==
    // rd_ptr when full, so the head is overwritten as it leaves).
    always_comb begin
        pop_ok    = READ_EN & ~EMPTY;
        push_ok   = WRITE_EN & (~FULL | pop_ok);
        count_nxt = COUNT + 4'(push_ok) - 4'(pop_ok);
    end

    // Show-ahead head entry; no bypass from DATA_IN.
    assign DATA_OUT = mem[rd_ptr];

    // Storage: cleared by reset only, CLR leaves contents in place.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!CLR && push_ok) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (CLR) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy and flags all load from count_nxt so they always agree.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            COUNT <= 4'd0;
            FREE  <= DEPTH_W;
            FULL  <= 1'b0;
            EMPTY <= 1'b1;
        end else if (CLR) begin
            COUNT <= 4'd0;
            FREE  <= DEPTH_W;
            FULL  <= 1'b0;
            EMPTY <= 1'b1;
        end else begin
            COUNT <= count_nxt;
            FREE  <= DEPTH_W - count_nxt;
            FULL  <= (count_nxt == DEPTH_W);
            EMPTY <= (count_nxt == 4'd0);
        end
    end

    // Error pulses: one cycle per rejected op, suppressed by CLR.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else if (CLR) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            OVERFLOW  <= WRITE_EN & ~push_ok;
            UNDERFLOW <= READ_EN & ~pop_ok;
        end
    end

endmodule

// File: tb/tb_mpsoc_dbg_bytefifo.sv
// Directed bench for mpsoc_dbg_bytefifo (DEPTH=8, DW=8).
module tb_mpsoc_dbg_bytefifo;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       CLR = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       WRITE_EN = 1'b0;
    logic       READ_EN = 1'b0;
    logic [7:0] DATA_OUT;
    logic [3:0] COUNT;
    logic [3:0] FREE;
    logic       FULL;
    logic       EMPTY;
    logic       OVERFLOW;
    logic       UNDERFLOW;

    int n_pass = 0;
    int n_tot  = 0;

    mpsoc_dbg_bytefifo #(.DEPTH(8), .DW(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .DATA_IN(DATA_IN),
        .WRITE_EN(WRITE_EN), .READ_EN(READ_EN), .DATA_OUT(DATA_OUT),
        .COUNT(COUNT), .FREE(FREE), .FULL(FULL), .EMPTY(EMPTY),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of stimulus from a negedge; return at the next negedge.
    task automatic cyc(input logic we, input logic re, input logic clr, input logic [7:0] d);
        WRITE_EN = we; READ_EN = re; CLR = clr; DATA_IN = d;
        @(posedge CLK);
        @(negedge CLK);
        WRITE_EN = 1'b0; READ_EN = 1'b0; CLR = 1'b0; DATA_IN = 8'h00;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        @(negedge CLK); @(negedge CLK);
        n_tot++; if (COUNT !== 4'd0) $display("FAIL rst_count got %0d exp 0", COUNT); else n_pass++;
        n_tot++; if (FREE !== 4'd8) $display("FAIL rst_free got %0d exp 8", FREE); else n_pass++;
        n_tot++; if (EMPTY !== 1'b1 || FULL !== 1'b0) $display("FAIL rst_flags got e=%b f=%b exp e=1 f=0", EMPTY, FULL); else n_pass++;
        n_tot++; if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) $display("FAIL rst_pulses got o=%b u=%b exp 0 0", OVERFLOW, UNDERFLOW); else n_pass++;
        n_tot++; if (DATA_OUT !== 8'h00) $display("FAIL rst_data got %h exp 00", DATA_OUT); else n_pass++;
        RSTN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_write();
        cyc(1'b1, 1'b0, 1'b0, 8'hA5);
        n_tot++; if (COUNT !== 4'd1) $display("FAIL wr1_count got %0d exp 1", COUNT); else n_pass++;
        n_tot++; if (EMPTY !== 1'b0) $display("FAIL wr1_empty got %b exp 0", EMPTY); else n_pass++;
        n_tot++; if (FREE !== 4'd7) $display("FAIL wr1_free got %0d exp 7", FREE); else n_pass++;
        n_tot++; if (DATA_OUT !== 8'hA5) $display("FAIL wr1_data got %h exp a5", DATA_OUT); else n_pass++;
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        n_tot++; if (COUNT !== 4'd0 || EMPTY !== 1'b1) $display("FAIL wr1_drain got c=%0d e=%b exp c=0 e=1", COUNT, EMPTY); else n_pass++;
    endtask

    task automatic test_full_overflow();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        n_tot++; if (FULL !== 1'b1 || COUNT !== 4'd8 || FREE !== 4'd0)
            $display("FAIL full_state got f=%b c=%0d fr=%0d exp f=1 c=8 fr=0", FULL, COUNT, FREE); else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, 8'hFF);
        n_tot++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_pulse got %b exp 1", OVERFLOW); else n_pass++;
        n_tot++; if (COUNT !== 4'd8) $display("FAIL ovf_count got %0d exp 8", COUNT); else n_pass++;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        n_tot++; if (OVERFLOW !== 1'b0) $display("FAIL ovf_clear got %b exp 0", OVERFLOW); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            n_tot++; if (DATA_OUT !== 8'(i)) $display("FAIL full_read%0d got %h exp %h", i, DATA_OUT, 8'(i)); else n_pass++;
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end
        n_tot++; if (EMPTY !== 1'b1 || COUNT !== 4'd0) $display("FAIL full_drain got e=%b c=%0d exp e=1 c=0", EMPTY, COUNT); else n_pass++;
    endtask

    task automatic test_underflow();
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        n_tot++; if (UNDERFLOW !== 1'b1) $display("FAIL udf_pulse got %b exp 1", UNDERFLOW); else n_pass++;
        n_tot++; if (COUNT !== 4'd0) $display("FAIL udf_count got %0d exp 0", COUNT); else n_pass++;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        n_tot++; if (UNDERFLOW !== 1'b0) $display("FAIL udf_clear got %b exp 0", UNDERFLOW); else n_pass++;
        // a moved read pointer would show a stale entry instead of the new byte
        cyc(1'b1, 1'b0, 1'b0, 8'h77);
        n_tot++; if (DATA_OUT !== 8'h77) $display("FAIL udf_ptr got %h exp 77", DATA_OUT); else n_pass++;
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_wrap();
        int errs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
            n_tot++; if (DATA_OUT !== 8'(8'h10 + i) || COUNT !== 4'd1) begin
                $display("FAIL wrap_wr%0d got d=%h c=%0d exp d=%h c=1", i, DATA_OUT, COUNT, 8'(8'h10 + i)); errs++;
            end else n_pass++;
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            n_tot++; if (COUNT !== 4'd0 || UNDERFLOW !== 1'b0 || OVERFLOW !== 1'b0) begin
                $display("FAIL wrap_rd%0d got c=%0d u=%b o=%b exp c=0 u=0 o=0", i, COUNT, UNDERFLOW, OVERFLOW); errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        // empty: push only, pop rejected
        cyc(1'b1, 1'b1, 1'b0, 8'h30);
        n_tot++; if (COUNT !== 4'd1 || UNDERFLOW !== 1'b1) $display("FAIL sim0 got c=%0d u=%b exp c=1 u=1", COUNT, UNDERFLOW); else n_pass++;
        n_tot++; if (DATA_OUT !== 8'h30) $display("FAIL sim0_data got %h exp 30", DATA_OUT); else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, 8'h31);
        cyc(1'b1, 1'b0, 1'b0, 8'h32);
        // COUNT=3: both succeed
        cyc(1'b1, 1'b1, 1'b0, 8'h33);
        n_tot++; if (COUNT !== 4'd3 || UNDERFLOW !== 1'b0 || OVERFLOW !== 1'b0)
            $display("FAIL sim3 got c=%0d u=%b o=%b exp c=3 u=0 o=0", COUNT, UNDERFLOW, OVERFLOW); else n_pass++;
        n_tot++; if (DATA_OUT !== 8'h31) $display("FAIL sim3_data got %h exp 31", DATA_OUT); else n_pass++;
        for (int i = 4; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        n_tot++; if (FULL !== 1'b1) $display("FAIL sim8_pre got f=%b exp 1", FULL); else n_pass++;
        // full: both succeed, written slot is the one freed
        cyc(1'b1, 1'b1, 1'b0, 8'h39);
        n_tot++; if (COUNT !== 4'd8 || FULL !== 1'b1 || OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0)
            $display("FAIL sim8 got c=%0d f=%b o=%b u=%b exp c=8 f=1 o=0 u=0", COUNT, FULL, OVERFLOW, UNDERFLOW); else n_pass++;
        for (int i = 2; i <= 9; i++) begin
            n_tot++; if (DATA_OUT !== 8'(8'h30 + i)) $display("FAIL sim8_read%0d got %h exp %h", i, DATA_OUT, 8'(8'h30 + i)); else n_pass++;
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end
        n_tot++; if (EMPTY !== 1'b1) $display("FAIL sim_drain got e=%b exp 1", EMPTY); else n_pass++;
    endtask

    task automatic test_clr_and_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
        n_tot++; if (COUNT !== 4'd5) $display("FAIL clr_pre got %0d exp 5", COUNT); else n_pass++;
        cyc(1'b1, 1'b0, 1'b1, 8'hEE);
        n_tot++; if (COUNT !== 4'd0 || EMPTY !== 1'b1 || FREE !== 4'd8 || FULL !== 1'b0)
            $display("FAIL clr_state got c=%0d e=%b fr=%0d f=%b exp c=0 e=1 fr=8 f=0", COUNT, EMPTY, FREE, FULL); else n_pass++;
        n_tot++; if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) $display("FAIL clr_pulses got o=%b u=%b exp 0 0", OVERFLOW, UNDERFLOW); else n_pass++;
        // CLR with a pop on an empty FIFO still gives no pulse
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        n_tot++; if (UNDERFLOW !== 1'b0) $display("FAIL clr_udf got %b exp 0", UNDERFLOW); else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, 8'h61);
        n_tot++; if (DATA_OUT !== 8'h61 || COUNT !== 4'd1) $display("FAIL clr_after got d=%h c=%0d exp d=61 c=1", DATA_OUT, COUNT); else n_pass++;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h62 + i));
        n_tot++; if (COUNT !== 4'd5) $display("FAIL arst_pre got %0d exp 5", COUNT); else n_pass++;
        // drop reset between edges; outputs must follow without a clock edge
        #2 RSTN = 1'b0;
        #1;
        n_tot++; if (COUNT !== 4'd0 || EMPTY !== 1'b1 || FREE !== 4'd8)
            $display("FAIL arst_state got c=%0d e=%b fr=%0d exp c=0 e=1 fr=8", COUNT, EMPTY, FREE); else n_pass++;
        n_tot++; if (DATA_OUT !== 8'h00) $display("FAIL arst_data got %h exp 00", DATA_OUT); else n_pass++;
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        n_tot++; if (COUNT !== 4'd0 || DATA_OUT !== 8'h00) $display("FAIL arst_after got c=%0d d=%h exp c=0 d=00", COUNT, DATA_OUT); else n_pass++;
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_single_write();
        test_full_overflow();
        test_underflow();
        test_wrap();
        test_simultaneous();
        test_clr_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // Safety net: bench must always terminate.
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
